// File: rtl/vx_fpu_pkg.sv
// Shared FPU types and widths.
// Used by the FPU result gather stage.
package VX_fpu_pkg;

   localparam int XLEN          = 32;
   localparam int FP_FLAGS_BITS = 5;

   typedef struct packed {
      logic nv;
      logic dz;
      logic of;
      logic uf;
      logic nx;
   } fflags_t;

endpackage

// File: rtl/vx_fpu_gather.sv
// Gathers per-batch FPU results into one full-width response.
// The accumulator register is also the output register.
module vx_fpu_gather
   import VX_fpu_pkg::*;
#(
   parameter  int NUM_LANES   = 4,
   parameter  int BATCH_LANES = 1,
   parameter  int TAG_WIDTH   = 1,
   localparam int NUM_BATCHES = NUM_LANES / BATCH_LANES,
   localparam int BATCH_SEL_BITS =
      (NUM_BATCHES > 1) ? $clog2(NUM_BATCHES) : 1
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         valid_in,
   output logic                         ready_in,
   input  logic [BATCH_LANES*XLEN-1:0]  data_in,
   input  logic                         has_fflags_in,
   input  logic [FP_FLAGS_BITS-1:0]     fflags_in,
   input  logic [BATCH_SEL_BITS-1:0]    batch_idx_in,
   input  logic                         batch_last_in,
   input  logic [TAG_WIDTH-1:0]         tag_in,
   output logic                         valid_out,
   input  logic                         ready_out,
   output logic [NUM_LANES*XLEN-1:0]    result,
   output logic                         has_fflags,
   output logic [FP_FLAGS_BITS-1:0]     fflags,
   output logic [TAG_WIDTH-1:0]         tag_out
);

   localparam int BW = BATCH_LANES * XLEN;

   typedef enum logic {
      ST_COLLECT,
      ST_EMIT
   } state_e;

   state_e                      r_state;
   state_e                      w_state_nxt;
   logic [NUM_LANES*XLEN-1:0]   r_result;
   logic                        r_has;
   fflags_t                     r_fflags;
   logic [TAG_WIDTH-1:0]        r_tag;
   logic                        r_started;
   logic [BATCH_SEL_BITS-1:0]   r_prev_idx;
   logic [TAG_WIDTH-1:0]        r_req_tag;
   logic                        w_fire;
   logic                        w_first;

   assign w_fire  = valid_in && ready_in;
   // A beat accepted in EMIT always coincides with the output handshake.
   assign w_first = (r_state == ST_EMIT) || !r_started;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_COLLECT;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         ST_COLLECT: begin
            if (w_fire && batch_last_in) begin
               w_state_nxt = ST_EMIT;
            end
         end
         ST_EMIT: begin
            if (ready_out) begin
               w_state_nxt = (w_fire && batch_last_in)
                           ? ST_EMIT : ST_COLLECT;
            end
         end
      endcase
   end

   always_comb begin
      valid_out = (r_state == ST_EMIT);
      ready_in  = (r_state == ST_COLLECT) || ready_out;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_result   <= '0;
         r_has      <= 1'b0;
         r_fflags   <= '0;
         r_tag      <= '0;
         r_started  <= 1'b0;
         r_prev_idx <= '0;
         r_req_tag  <= '0;
      end else if (w_fire) begin
         for (int b = 0; b < NUM_BATCHES; b++) begin
            if (b == int'(batch_idx_in)) begin
               r_result[b*BW +: BW] <= data_in;
            end else if (w_first) begin
               r_result[b*BW +: BW] <= '0;
            end
         end
         if (w_first) begin
            r_has    <= has_fflags_in;
            r_fflags <= has_fflags_in ? fflags_t'(fflags_in) : '0;
         end else begin
            r_has <= r_has | has_fflags_in;
            if (has_fflags_in) begin
               r_fflags <= fflags_t'(r_fflags | fflags_in);
            end
         end
         if (batch_last_in) begin
            r_tag <= tag_in;
         end
         r_started  <= !batch_last_in;
         r_prev_idx <= batch_idx_in;
         r_req_tag  <= tag_in;
      end
   end

   assign result     = r_result;
   assign has_fflags = r_has;
   assign fflags     = r_fflags;
   assign tag_out    = r_tag;

`ifndef SYNTHESIS
   localparam logic [BATCH_SEL_BITS:0] IDX_LIM =
      (BATCH_SEL_BITS+1)'(NUM_BATCHES);

   always_ff @(posedge clk) begin
      if (!reset && w_fire) begin
         assert ({1'b0, batch_idx_in} < IDX_LIM)
            else $error("batch_idx_in out of range");
         if (!w_first) begin
            assert (batch_idx_in > r_prev_idx)
               else $error("batch_idx_in not increasing");
            assert (tag_in == r_req_tag)
               else $error("tag_in changed within request");
         end
      end
   end
`endif

endmodule

// File: tb/tb_vx_fpu_gather.sv
// Scoreboard bench for vx_fpu_gather.
// Four lanes, one lane per beat, 4-bit tags.
module tb_vx_fpu_gather;
   import VX_fpu_pkg::*;

   localparam int NL = 4;
   localparam int BL = 1;
   localparam int TW = 4;
   localparam int SB = 2;
   localparam int RW = NL * XLEN;

   typedef struct packed {
      logic [RW-1:0]            res;
      logic                     has;
      logic [FP_FLAGS_BITS-1:0] ff;
      logic [TW-1:0]            tag;
   } exp_t;

   logic                     clk = 1'b0;
   logic                     reset;
   logic                     valid_in;
   logic                     ready_in;
   logic [BL*XLEN-1:0]       data_in;
   logic                     has_fflags_in;
   logic [FP_FLAGS_BITS-1:0] fflags_in;
   logic [SB-1:0]            batch_idx_in;
   logic                     batch_last_in;
   logic [TW-1:0]            tag_in;
   logic                     valid_out;
   logic                     ready_out;
   logic [RW-1:0]            result;
   logic                     has_fflags;
   logic [FP_FLAGS_BITS-1:0] fflags;
   logic [TW-1:0]            tag_out;

   exp_t q[$];
   exp_t e;
   int   n_vec  = 0;
   int   n_err  = 0;
   int   n_resp = 0;
   int   n_wait = 0;

   logic [RW-1:0]            m_res;
   logic                     m_has;
   logic [FP_FLAGS_BITS-1:0] m_ff;
   bit                       m_open = 1'b0;

   vx_fpu_gather #(
      .NUM_LANES   (NL),
      .BATCH_LANES (BL),
      .TAG_WIDTH   (TW)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .valid_in      (valid_in),
      .ready_in      (ready_in),
      .data_in       (data_in),
      .has_fflags_in (has_fflags_in),
      .fflags_in     (fflags_in),
      .batch_idx_in  (batch_idx_in),
      .batch_last_in (batch_last_in),
      .tag_in        (tag_in),
      .valid_out     (valid_out),
      .ready_out     (ready_out),
      .result        (result),
      .has_fflags    (has_fflags),
      .fflags        (fflags),
      .tag_out       (tag_out)
   );

   always #5 clk = ~clk;

   // Response side: pop the oldest expected response on every handshake.
   always @(negedge clk) begin
      if (!reset && valid_out && ready_out) begin
         n_resp++;
         n_vec++;
         if (q.size() == 0) begin
            n_err++;
            $display("FAIL resp_unexpected got tag=%0h res=%h",
                     tag_out, result);
         end else begin
            e = q.pop_front();
            if ({result, has_fflags, fflags, tag_out} !== e) begin
               n_err++;
               $display("FAIL resp got res=%h has=%b ff=%h tag=%h exp res=%h has=%b ff=%h tag=%h",
                        result, has_fflags, fflags, tag_out,
                        e.res, e.has, e.ff, e.tag);
            end
         end
      end
   end

   task automatic beat(input int idx, input logic [XLEN-1:0] d,
                       input logic hf, input logic [4:0] ff,
                       input logic last, input logic [TW-1:0] tg);
      int cnt = 0;
      valid_in      = 1'b1;
      data_in       = d;
      has_fflags_in = hf;
      fflags_in     = ff;
      batch_idx_in  = idx[SB-1:0];
      batch_last_in = last;
      tag_in        = tg;
      @(negedge clk);
      while (!ready_in && cnt < 50) begin
         cnt++;
         @(negedge clk);
      end
      if (!ready_in) begin
         n_vec++;
         n_err++;
         $display("FAIL beat_accept ready_in=%b after %0d cycles, need 1",
                  ready_in, cnt);
      end
      n_wait += cnt;
      @(posedge clk);
      #1;
      valid_in = 1'b0;
      if (!m_open) begin
         m_res = '0;
         m_has = 1'b0;
         m_ff  = '0;
      end
      m_res[idx*XLEN +: XLEN] = d;
      m_has = m_has | hf;
      if (hf) m_ff = m_ff | ff;
      m_open = !last;
      if (last) q.push_back({m_res, m_has, m_ff, tg});
   endtask

   task automatic drain(input string nm);
      int t = 0;
      while (q.size() != 0 && t < 20) begin
         @(negedge clk);
         t++;
      end
      n_vec++;
      if (q.size() != 0) begin
         n_err++;
         $display("FAIL %s_drain pending=%0d, need 0", nm, q.size());
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset     = 1'b1;
      valid_in  = 1'b0;
      ready_out = 1'b0;
      data_in   = '0;
      has_fflags_in = 1'b0;
      fflags_in     = '0;
      batch_idx_in  = '0;
      batch_last_in = 1'b0;
      tag_in        = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_vec++;
      if ({valid_out, ready_in} !== 2'b01) begin
         n_err++;
         $display("FAIL rst_hs got v=%b r=%b, need v=0 r=1",
                  valid_out, ready_in);
      end
      n_vec++;
      if ({result, has_fflags, fflags, tag_out} !== '0) begin
         n_err++;
         $display("FAIL rst_vals got res=%h has=%b ff=%h tag=%h, need 0",
                  result, has_fflags, fflags, tag_out);
      end
      @(posedge clk);
      #1;
      reset  = 1'b0;
      m_open = 1'b0;
   endtask

   task automatic test_basic();
      logic [4:0] ffv [4] = '{5'h01, 5'h00, 5'h04, 5'h00};
      ready_out = 1'b1;
      for (int i = 0; i < 4; i++)
         beat(i, 32'h10 + i, 1'b1, ffv[i], i == 3, 4'd5);
      @(negedge clk);
      n_vec++;
      if (valid_out !== 1'b1 ||
          result !== {32'h13, 32'h12, 32'h11, 32'h10} ||
          fflags !== 5'h05 || has_fflags !== 1'b1 ||
          tag_out !== 4'd5) begin
         n_err++;
         $display("FAIL basic got v=%b res=%h ff=%h has=%b tag=%h",
                  valid_out, result, fflags, has_fflags, tag_out);
      end
      drain("basic");
   endtask

   task automatic test_skip();
      ready_out = 1'b1;
      beat(1, 32'hA, 1'b0, 5'h00, 1'b0, 4'd2);
      beat(3, 32'hB, 1'b0, 5'h00, 1'b1, 4'd2);
      @(negedge clk);
      n_vec++;
      if (result !== {32'hB, 32'h0, 32'hA, 32'h0} ||
          has_fflags !== 1'b0 || tag_out !== 4'd2) begin
         n_err++;
         $display("FAIL skip got res=%h has=%b tag=%h, need res=%h",
                  result, has_fflags, tag_out,
                  {32'hB, 32'h0, 32'hA, 32'h0});
      end
      drain("skip");
   endtask

   task automatic test_stall();
      ready_out = 1'b0;
      for (int i = 0; i < 4; i++)
         beat(i, 32'h20 + i, 1'b1, 5'(1 << i), i == 3, 4'd3);
      valid_in      = 1'b1;
      data_in       = 32'h55;
      has_fflags_in = 1'b1;
      fflags_in     = 5'h10;
      batch_idx_in  = 2'd3;
      batch_last_in = 1'b1;
      tag_in        = 4'd4;
      repeat (3) begin
         @(negedge clk);
         n_vec++;
         if (valid_out !== 1'b1 || ready_in !== 1'b0 ||
             q.size() != 1 ||
             {result, has_fflags, fflags, tag_out} !== q[0]) begin
            n_err++;
            $display("FAIL stall_hold got v=%b rdy=%b res=%h ff=%h tag=%h",
                     valid_out, ready_in, result, fflags, tag_out);
         end
      end
      @(posedge clk);
      #1;
      ready_out = 1'b1;
      beat(3, 32'h55, 1'b1, 5'h10, 1'b1, 4'd4);
      @(negedge clk);
      n_vec++;
      if (valid_out !== 1'b1 || tag_out !== 4'd4 ||
          result !== {32'h55, 96'h0}) begin
         n_err++;
         $display("FAIL stall_release got v=%b tag=%h res=%h, need v=1 tag=4",
                  valid_out, tag_out, result);
      end
      drain("stall");
   endtask

   task automatic test_back_to_back();
      int r0 = n_resp;
      int w0 = n_wait;
      ready_out = 1'b1;
      for (int r = 0; r < 3; r++)
         for (int i = 0; i < 4; i++)
            beat(i, $urandom, 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 31)), i == 3, 4'(8 + r));
      drain("b2b");
      n_vec++;
      if (n_resp - r0 != 3 || n_wait - w0 != 0) begin
         n_err++;
         $display("FAIL b2b got resp=%0d waits=%0d, need resp=3 waits=0",
                  n_resp - r0, n_wait - w0);
      end
   endtask

   task automatic test_reset_mid();
      ready_out = 1'b1;
      beat(0, 32'h30, 1'b1, 5'h08, 1'b0, 4'd6);
      beat(1, 32'h31, 1'b1, 5'h08, 1'b0, 4'd6);
      reset  = 1'b1;
      m_open = 1'b0;
      @(posedge clk);
      repeat (2) begin
         @(negedge clk);
         n_vec++;
         if (valid_out !== 1'b0 || result !== '0 || fflags !== '0) begin
            n_err++;
            $display("FAIL rstmid got v=%b res=%h ff=%h, need all 0",
                     valid_out, result, fflags);
         end
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
      for (int i = 0; i < 4; i++)
         beat(i, 32'h70 + i, 1'b1, 5'h00, i == 3, 4'd7);
      @(negedge clk);
      n_vec++;
      if (tag_out !== 4'd7 || fflags !== 5'h00 ||
          result !== {32'h73, 32'h72, 32'h71, 32'h70}) begin
         n_err++;
         $display("FAIL rstmid_new got tag=%h ff=%h res=%h, need tag=7 ff=0",
                  tag_out, fflags, result);
      end
      drain("rstmid");
   endtask

   task automatic test_noflags();
      ready_out = 1'b1;
      for (int i = 0; i < 4; i++)
         beat(i, 32'h40 + i, 1'b0, 5'h1F, i == 3, 4'd1);
      @(negedge clk);
      n_vec++;
      if (has_fflags !== 1'b0 || fflags !== 5'h00) begin
         n_err++;
         $display("FAIL noflags got has=%b ff=%h, need has=0 ff=0",
                  has_fflags, fflags);
      end
      drain("noflags");
   endtask

   initial begin
      test_reset();
      test_basic();
      test_skip();
      test_stall();
      test_back_to_back();
      test_reset_mid();
      test_noflags();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

endmodule
